// File: rtl/uvma_clk_div_gen.sv
// uvma_clk_div_gen: multi-channel integer clock divider.
// Each channel has a programmable period and high time. A new setting is held
// in a per-channel shadow and takes effect only at a period boundary, or at
// once if the channel is idle, so every output edge stays clean.
// Optional feature macro: UVMA_CLK_DIV_GEN_PHASE_ALIGN_EN adds the align input.
// A one-cycle align pulse restarts every active channel at cnt=0.
module uvma_clk_div_gen #(
  parameter int NUM_CHAN       = 4,
  parameter int CNT_W          = 16,
  parameter int DEFAULT_PERIOD = 4,
  parameter int DEFAULT_HIGH   = 2,
  localparam int CH_W          = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_CHAN-1:0] en,
`ifdef UVMA_CLK_DIV_GEN_PHASE_ALIGN_EN
  input  logic                align,
`endif
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_chan,
  input  logic [CNT_W-1:0]    cfg_period,
  input  logic [CNT_W-1:0]    cfg_high,
  output logic                cfg_err,
  output logic [NUM_CHAN-1:0] clk_out,
  output logic [NUM_CHAN-1:0] running,
  output logic [NUM_CHAN-1:0] wrap
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STOP = 2'd2
  } state_t;

  state_t             state_q  [NUM_CHAN];
  state_t             state_d  [NUM_CHAN];
  logic [CNT_W-1:0]   cnt_q    [NUM_CHAN];
  logic [CNT_W-1:0]   cnt_d    [NUM_CHAN];
  logic [CNT_W-1:0]   per_q    [NUM_CHAN];
  logic [CNT_W-1:0]   per_d    [NUM_CHAN];
  logic [CNT_W-1:0]   hi_q     [NUM_CHAN];
  logic [CNT_W-1:0]   hi_d     [NUM_CHAN];
  logic [CNT_W-1:0]   sh_per_q [NUM_CHAN];
  logic [CNT_W-1:0]   sh_per_d [NUM_CHAN];
  logic [CNT_W-1:0]   sh_hi_q  [NUM_CHAN];
  logic [CNT_W-1:0]   sh_hi_d  [NUM_CHAN];
  logic [NUM_CHAN-1:0] pend_q, pend_d;
  logic [NUM_CHAN-1:0] clk_q, clk_d;
  logic                cfg_err_q, cfg_err_d;

  logic                cfg_legal, cfg_acc;
  logic                act, last, apply;
  logic [CNT_W-1:0]    nxt;

  assign clk_out = clk_q;
  assign cfg_err = cfg_err_q;

  // State register: channel FSMs, counters, active/shadow config, flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CHAN; i++) begin
        state_q[i]  <= S_IDLE;
        cnt_q[i]    <= '0;
        per_q[i]    <= CNT_W'(DEFAULT_PERIOD);
        hi_q[i]     <= CNT_W'(DEFAULT_HIGH);
        sh_per_q[i] <= '0;
        sh_hi_q[i]  <= '0;
      end
      pend_q    <= '0;
      clk_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      per_q     <= per_d;
      hi_q      <= hi_d;
      sh_per_q  <= sh_per_d;
      sh_hi_q   <= sh_hi_d;
      pend_q    <= pend_d;
      clk_q     <= clk_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  // Next-state logic: per-channel FSM, config handshake and shadow transfer.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    per_d     = per_q;
    hi_d      = hi_q;
    sh_per_d  = sh_per_q;
    sh_hi_d   = sh_hi_q;
    pend_d    = pend_q;
    clk_d     = clk_q;
    running   = '0;
    wrap      = '0;
    act       = 1'b0;
    last      = 1'b0;
    apply     = 1'b0;
    nxt       = '0;

    // A channel with a write still waiting for its boundary stalls new writes.
    cfg_ready = 1'b1;
    for (int i = 0; i < NUM_CHAN; i++) begin
      if (cfg_chan == CH_W'(i)) cfg_ready = !pend_q[i];
    end
    cfg_acc   = cfg_valid && cfg_ready;
    cfg_legal = (cfg_period >= CNT_W'(2)) && (cfg_high != '0) &&
                (cfg_high < cfg_period) && (int'(cfg_chan) < NUM_CHAN);
    cfg_err_d = cfg_acc && !cfg_legal;

    for (int i = 0; i < NUM_CHAN; i++) begin
      act        = (state_q[i] != S_IDLE);
      last       = act && (cnt_q[i] == per_q[i] - CNT_W'(1));
      nxt        = last ? '0 : cnt_q[i] + CNT_W'(1);
      apply      = 1'b0;
      running[i] = act;
      wrap[i]    = last;

      if (!act) begin
        cnt_d[i] = '0;
        clk_d[i] = 1'b0;
        apply    = pend_q[i];
        if (en[i]) begin
          state_d[i] = S_RUN;
          clk_d[i]   = 1'b1;
        end
      end else begin
        // At a wrap nxt is 0 and any legal high is >= 1, so clk_d is 1
        // whether the old or the new high time applies.
        cnt_d[i] = nxt;
        clk_d[i] = (nxt < hi_q[i]);
        apply    = last && pend_q[i];
        if (en[i]) begin
          state_d[i] = S_RUN;
        end else if (last) begin
          state_d[i] = S_IDLE;
          cnt_d[i]   = '0;
          clk_d[i]   = 1'b0;
        end else begin
          state_d[i] = S_STOP;
        end
      end

`ifdef UVMA_CLK_DIV_GEN_PHASE_ALIGN_EN
      // Align restarts every channel that stays active after this edge.
      if (align && act && (state_d[i] != S_IDLE)) begin
        cnt_d[i] = '0;
        clk_d[i] = 1'b1;
        apply    = pend_q[i];
      end
`endif

      if (apply) begin
        per_d[i]  = sh_per_q[i];
        hi_d[i]   = sh_hi_q[i];
        pend_d[i] = 1'b0;
      end

      // Accepted writes only reach channels with no pending shadow, so they
      // never collide with a transfer on the same channel.
      if (cfg_acc && cfg_legal && (cfg_chan == CH_W'(i))) begin
        sh_per_d[i] = cfg_period;
        sh_hi_d[i]  = cfg_high;
        pend_d[i]   = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uvma_clk_div_gen.sv
// Testbench for uvma_clk_div_gen: directed scenarios followed by random
// enables and config writes, all compared each cycle against a period/phase
// reference model.
module tb_uvma_clk_div_gen;
  localparam int NC = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NC-1:0] en = '0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [1:0]    cfg_chan = '0;
  logic [CW-1:0] cfg_period = '0;
  logic [CW-1:0] cfg_high = '0;
  logic          cfg_err;
  logic [NC-1:0] clk_out, running, wrap;
`ifdef UVMA_CLK_DIV_GEN_PHASE_ALIGN_EN
  logic          align = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: each channel is either off or at phase m_pos within a
  // period of m_per cycles; a pending write waits in m_sper/m_shi.
  bit m_on   [NC];
  int m_pos  [NC];
  int m_per  [NC];
  int m_hi   [NC];
  int m_sper [NC];
  int m_shi  [NC];
  bit m_pend [NC];
  bit m_err;

  uvma_clk_div_gen #(
    .NUM_CHAN(NC), .CNT_W(CW), .DEFAULT_PERIOD(4), .DEFAULT_HIGH(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .en(en),
`ifdef UVMA_CLK_DIV_GEN_PHASE_ALIGN_EN
    .align(align),
`endif
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_chan(cfg_chan),
    .cfg_period(cfg_period),
    .cfg_high(cfg_high),
    .cfg_err(cfg_err),
    .clk_out(clk_out),
    .running(running),
    .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      m_on[i] = 1'b0; m_pos[i] = 0; m_per[i] = 4; m_hi[i] = 2;
      m_sper[i] = 0; m_shi[i] = 0; m_pend[i] = 1'b0;
    end
    m_err = 1'b0;
  endtask

  task automatic model_apply(input int i);
    if (m_pend[i]) begin
      m_per[i] = m_sper[i]; m_hi[i] = m_shi[i]; m_pend[i] = 1'b0;
    end
  endtask

  // Advance the model by one source-clock edge using the current inputs.
  task automatic model_step();
    int ch;
    bit acc, legal, last, was_on;
    ch    = int'(cfg_chan);
    acc   = cfg_valid && !m_pend[ch];
    legal = (cfg_period >= 2) && (cfg_high != 0) && (cfg_high < cfg_period) && (ch < NC);
    for (int i = 0; i < NC; i++) begin
      was_on = m_on[i];
      if (!m_on[i]) begin
        model_apply(i);
        if (en[i]) begin m_on[i] = 1'b1; m_pos[i] = 0; end
      end else begin
        last = (m_pos[i] == m_per[i] - 1);
        m_pos[i] = last ? 0 : m_pos[i] + 1;
        if (last) model_apply(i);
        if (!en[i] && last) begin m_on[i] = 1'b0; m_pos[i] = 0; end
      end
`ifdef UVMA_CLK_DIV_GEN_PHASE_ALIGN_EN
      if (align && was_on && m_on[i]) begin
        m_pos[i] = 0;
        model_apply(i);
      end
`endif
    end
    m_err = acc && !legal;
    if (acc && legal) begin
      m_sper[ch] = int'(cfg_period); m_shi[ch] = int'(cfg_high); m_pend[ch] = 1'b1;
    end
  endtask

  task automatic check_outputs();
    logic [NC-1:0] e_clk, e_run, e_wrap;
    logic          e_rdy;
    for (int i = 0; i < NC; i++) begin
      e_clk[i]  = m_on[i] && (m_pos[i] < m_hi[i]);
      e_run[i]  = m_on[i];
      e_wrap[i] = m_on[i] && (m_pos[i] == m_per[i] - 1);
    end
    e_rdy = !m_pend[cfg_chan];
    checks++;
    assert (clk_out === e_clk) else begin
      errors++; $error("FAIL clk_out observed %b expected %b at %0t", clk_out, e_clk, $time);
    end
    checks++;
    assert (running === e_run) else begin
      errors++; $error("FAIL running observed %b expected %b at %0t", running, e_run, $time);
    end
    checks++;
    assert (wrap === e_wrap) else begin
      errors++; $error("FAIL wrap observed %b expected %b at %0t", wrap, e_wrap, $time);
    end
    checks++;
    assert (cfg_ready === e_rdy) else begin
      errors++; $error("FAIL cfg_ready observed %b expected %b at %0t", cfg_ready, e_rdy, $time);
    end
    checks++;
    assert (cfg_err === m_err) else begin
      errors++; $error("FAIL cfg_err observed %b expected %b at %0t", cfg_err, m_err, $time);
    end
  endtask

  // Check on the falling edge, then let the model take the rising edge.
  // Returns 1 time unit after the rising edge, where inputs may change.
  task automatic tick();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    #1;
    if (reset) model_reset();
    else model_step();
  endtask

  task automatic cfg_write(input int ch, input int p, input int h);
    cfg_valid  = 1'b1;
    cfg_chan   = 2'(ch);
    cfg_period = CW'(p);
    cfg_high   = CW'(h);
    tick();
    cfg_valid  = 1'b0;
  endtask

  initial begin
    model_reset();
    tick();
    tick();
    reset = 1'b0;

    // Channel 0 with default 4/2 starting at cycle 0.
    en[0] = 1'b1;
    repeat (13) tick();

    // Channel 1 at 10/3, reprogrammed mid-period to 6/1; a second write stalls.
    cfg_write(1, 10, 3);
    tick();
    en[1] = 1'b1;
    repeat (4) tick();
    cfg_write(1, 6, 1);
    cfg_valid = 1'b1; cfg_chan = 2'd1; cfg_period = CW'(7); cfg_high = CW'(2);
    repeat (12) tick();
    cfg_valid = 1'b0;
    repeat (14) tick();

    // Illegal write to channel 2: high == period.
    cfg_write(2, 5, 5);
    en[2] = 1'b1;
    repeat (10) tick();
    cfg_write(2, 1, 0);
    tick();

    // Channel 3 at 8/4, en dropped at cnt=1: full period completes.
    cfg_write(3, 8, 4);
    tick();
    en[3] = 1'b1;
    tick();
    tick();
    en[3] = 1'b0;
    repeat (10) tick();

    // Asynchronous reset while all channels run.
    en = '1;
    repeat (9) tick();
    #2 reset = 1'b1;
    #1;
    checks++;
    assert (clk_out === '0) else begin
      errors++; $error("FAIL async_reset clk_out observed %b expected 0000", clk_out);
    end
    checks++;
    assert (running === '0) else begin
      errors++; $error("FAIL async_reset running observed %b expected 0000", running);
    end
    model_reset();
    tick();
    reset = 1'b0;
    repeat (12) tick();

`ifdef UVMA_CLK_DIV_GEN_PHASE_ALIGN_EN
    // Periods 4 and 6 brought into phase by an align pulse.
    en = '0;
    repeat (8) tick();
    cfg_write(1, 6, 3);
    tick();
    en = 4'b0011;
    repeat (7) tick();
    align = 1'b1;
    tick();
    align = 1'b0;
    repeat (8) tick();
`endif

    // Random enables and config writes, legal and illegal.
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NC; i++) begin
        if ($urandom_range(0, 9) == 0) en[i] = ~en[i];
      end
      cfg_valid  = ($urandom_range(0, 3) == 0);
      cfg_chan   = 2'($urandom_range(0, NC - 1));
      cfg_period = CW'($urandom_range(0, 12));
      cfg_high   = CW'($urandom_range(0, int'(cfg_period) + 1));
`ifdef UVMA_CLK_DIV_GEN_PHASE_ALIGN_EN
      align = ($urandom_range(0, 19) == 0);
`endif
      tick();
    end
    cfg_valid = 1'b0;
    en = '0;
    repeat (20) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uvma_clk_div_gen.md
Name: uvma_clk_div_gen

Overview:
- Synthesizable multi-channel clock generator. Derives NUM_CHAN output clocks from one source clock by integer division, with programmable period and high time per channel.
- Runtime reconfiguration is glitch-free: new settings apply only at period boundaries. Start and stop are also glitch-free.
- Used as an emulation-friendly clock source in benches, and in DUT wrappers that need several derived clocks.

Parameters:
- NUM_CHAN, 4, number of independent output clock channels (1..16)
- CNT_W, 16, width of period/high counters; max period 2^CNT_W-1 source cycles
- DEFAULT_PERIOD, 4, active period of every channel after reset (source cycles)
- DEFAULT_HIGH, 2, active high time of every channel after reset (source cycles)

Ports:
- clk  in  1  source clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- en  in  NUM_CHAN  per-channel run request (level)
- cfg_valid  in  1  config write request
- cfg_ready  out  1  config write accepted when cfg_valid & cfg_ready
- cfg_chan  in  $clog2(NUM_CHAN) (min 1)  target channel
- cfg_period  in  CNT_W  new period in source cycles
- cfg_high  in  CNT_W  new high time in source cycles
- cfg_err  out  1  one-cycle pulse: last accepted write was illegal and was discarded
- clk_out  out  NUM_CHAN  generated clocks, registered
- running  out  NUM_CHAN  channel state is RUN or STOPPING
- wrap  out  NUM_CHAN  one-cycle pulse on the last source cycle of each period

Behaviour:
- Reset (async assert, sync release): clk_out=0, running=0, wrap=0, cfg_err=0, cfg_ready=1. All channels IDLE, cnt=0. Active config = DEFAULT_PERIOD/DEFAULT_HIGH. No pending shadow.
- Per-channel FSM:
  - IDLE→RUN when en=1 sampled. That edge sets cnt←0 and clk_out←1, so clk_out rises 1 cycle after en is sampled.
  - RUN: cnt←(cnt==period-1)?0:cnt+1; clk_out←(next_cnt<high).
  - RUN→STOPPING when en=0.
  - STOPPING counts exactly as RUN. At cnt==period-1 it goes →IDLE with clk_out←0 and cnt←0. A period is never truncated.
  - STOPPING→RUN when en=1 again, with no disturbance to the count.
- wrap[i]=1 on any cycle where the channel is in RUN/STOPPING and cnt==period-1.
- Config handshake:
  - cfg_ready = !pending[cfg_chan], combinational on cfg_chan.
  - An accepted legal write loads shadow[cfg_chan] and sets pending.
  - In IDLE, shadow is copied to active on the next cycle and pending clears.
  - In RUN/STOPPING, shadow is copied to active on the wrap cycle, so the next period uses the new values. pending clears on the same edge.
- Illegal write (any of: cfg_period<2, cfg_high==0, cfg_high>=cfg_period, cfg_chan>=NUM_CHAN):
  - The handshake still completes.
  - Shadow and pending are unchanged.
  - cfg_err=1 on the following cycle.
- Simultaneous events:
  - A write accepted on the wrap cycle takes effect at the following wrap, not the current one.
  - en deassert on the wrap cycle: the period just completing is the last one, and the channel goes IDLE at that edge.
- Reset mid-operation forces every channel IDLE with clk_out=0 immediately (async). All pending writes are lost.
- All counter arithmetic is unsigned CNT_W bits. period-1 never underflows because period≥2 is guaranteed.

Optional Feature:
- Macro UVMA_CLK_DIV_GEN_PHASE_ALIGN_EN.
- Defined:
  - Adds input align (1 bit). A one-cycle pulse restarts every channel in RUN/STOPPING at cnt=0 with clk_out=1 on the next edge, so all rising edges line up.
  - Pending shadows are applied at that edge.
  - wrap is not pulsed for truncated periods.
- Undefined: no align port. Channels are phase-independent and only restart from IDLE.

Test Plan:
- Reset, en[0]=1 at cycle 0 with defaults → clk_out[0] high cycles 1-2, low cycles 3-4, repeating; wrap[0] on cycles 4, 8, 12.
- Channel 1 running with period 10/high 3; write period 6/high 1 mid-period → old waveform completes, new 6/1 starts after wrap; cfg_ready[ch1]=0 until then; a second write to ch1 is stalled.
- Write period 5/high 5 to channel 2 → cfg_err pulses once; channel 2 keeps 4/2.
- en[3] dropped at cnt=1 of a period-8 clock → running[3] stays 1 until cnt=7; clk_out[3] ends low; no runt pulse.
- Assert reset while all 4 channels run → clk_out=0 and running=0 immediately; after release all channels use defaults.
- (PHASE_ALIGN_EN) channels with periods 4 and 6 running, pulse align → both clk_out rise on the same next edge.
